// File: rtl/bk_add_pkg.sv
// Shared types for the wide-add sequencer: chunk width, FSM state encoding
// and the chunk data type exchanged with the 16-bit adder stage.
package bk_add_pkg;

  localparam int CHUNK_W = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } seq_state_t;

  typedef logic [CHUNK_W-1:0] chunk_t;

endpackage

// File: rtl/bk_wide_add_seq.sv
// Sequencer that performs a WORDS*16-bit add by feeding an external 16-bit
// adder one chunk at a time (LSB chunk first), chaining each chunk's carry-out
// into the next chunk's carry-in, and presenting the assembled result.
//
// Handshakes: a transfer happens on a rising CLK edge where VALID and READY
// are both high. IN_READY is high only in IDLE. OUT_VALID is high only in
// DONE, and OUT_SUM/OUT_COUT hold steady until the OUT_READY transfer.
module bk_wide_add_seq
  import bk_add_pkg::*;
#(
  parameter int WORDS   = 4,
  parameter int ADD_LAT = 1
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     IN_VALID,
  output logic                     IN_READY,
  input  logic [WORDS*CHUNK_W-1:0] IN_A,
  input  logic [WORDS*CHUNK_W-1:0] IN_B,
  input  logic                     IN_CIN,
  output chunk_t                   ADD_A,
  output chunk_t                   ADD_B,
  output logic                     ADD_CIN,
  input  chunk_t                   ADD_S,
  input  logic                     ADD_COUT,
  output logic                     OUT_VALID,
  input  logic                     OUT_READY,
  output logic [WORDS*CHUNK_W-1:0] OUT_SUM,
  output logic                     OUT_COUT,
  output logic                     BUSY,
  output seq_state_t               DBG_STATE
);

  localparam int SUM_W = WORDS * CHUNK_W;
  localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int CNT_W = $clog2(ADD_LAT + 1);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(ADD_LAT);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  seq_state_t       state_q;
  seq_state_t       state_d;

  logic [SUM_W-1:0] a_q;
  logic [SUM_W-1:0] b_q;
  logic [SUM_W-1:0] sum_q;
  logic             carry_q;
  logic [IDX_W-1:0] idx_q;
  logic [CNT_W-1:0] cnt_q;
  chunk_t           add_a_q;
  chunk_t           add_b_q;
  logic             add_cin_q;

  logic             last_wait;
  logic             last_chunk;
  logic [IDX_W-1:0] idx_nxt;

  // The adder result is sampled on the final WAIT cycle of each chunk.
  assign last_wait  = (state_q == WAIT) && (cnt_q == CNT_ONE);
  assign last_chunk = (idx_q == LAST_IDX);
  assign idx_nxt    = idx_q + IDX_W'(1);

  // State register.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state decode and handshake/status outputs.
  always_comb begin
    state_d   = state_q;
    IN_READY  = 1'b0;
    OUT_VALID = 1'b0;
    BUSY      = 1'b1;
    case (state_q)
      IDLE: begin
        IN_READY = 1'b1;
        BUSY     = 1'b0;
        if (IN_VALID) begin
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        state_d = WAIT;
      end
      WAIT: begin
        if (last_wait) begin
          state_d = last_chunk ? DONE : ISSUE;
        end
      end
      DONE: begin
        OUT_VALID = 1'b1;
        if (OUT_READY) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Datapath: operand latch, chunk issue registers, wait counter, result assembly.
  always_ff @(posedge CLK) begin
    if (RST) begin
      a_q       <= '0;
      b_q       <= '0;
      sum_q     <= '0;
      carry_q   <= 1'b0;
      idx_q     <= '0;
      cnt_q     <= '0;
      add_a_q   <= '0;
      add_b_q   <= '0;
      add_cin_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (IN_VALID) begin
            a_q       <= IN_A;
            b_q       <= IN_B;
            carry_q   <= IN_CIN;
            idx_q     <= '0;
            // Chunk 0 goes out on the very next cycle, so load it directly.
            add_a_q   <= IN_A[CHUNK_W-1:0];
            add_b_q   <= IN_B[CHUNK_W-1:0];
            add_cin_q <= IN_CIN;
          end
        end
        ISSUE: begin
          cnt_q <= CNT_LOAD;
        end
        WAIT: begin
          cnt_q <= cnt_q - CNT_ONE;
          if (cnt_q == CNT_ONE) begin
            sum_q[idx_q*CHUNK_W +: CHUNK_W] <= ADD_S;
            carry_q                         <= ADD_COUT;
            // The adder inputs only move when another chunk follows, so they
            // keep their last values through DONE and IDLE.
            if (!last_chunk) begin
              idx_q     <= idx_nxt;
              add_a_q   <= a_q[idx_nxt*CHUNK_W +: CHUNK_W];
              add_b_q   <= b_q[idx_nxt*CHUNK_W +: CHUNK_W];
              add_cin_q <= ADD_COUT;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign ADD_A     = add_a_q;
  assign ADD_B     = add_b_q;
  assign ADD_CIN   = add_cin_q;
  assign OUT_SUM   = sum_q;
  assign OUT_COUT  = carry_q;
  assign DBG_STATE = state_q;

endmodule
